id_scoreboard: RTL and testbench

- Decode-stage interlock controller. It sequences instruction issue from the decode stage into the execute/memory pipeline.
- Tracks in-flight writes to the 32 GPRs and 32 FPRs with per-register countdown timers.
- Stalls decode on RAW/WAW hazards and on write-port collisions. GPR file and FPR file each have one write port per cycle.
- Sits beside the decode stage's control logic and register files; consumes decoded register fields and produces stall/issue.

---
 rtl/id_scoreboard.sv | 111 +++++++++++
 tb/tb_id_scoreboard.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Decode-stage interlock: per-register writeback countdown timers for the GPR and FPR files,
// plus a per-file write-port reservation vector. Stalls decode on RAW, WAW and port collisions.
module id_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned LATW = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    dec_valid,
  input  logic [$clog2(NREG)-1:0] dec_rs,
  input  logic [$clog2(NREG)-1:0] dec_rt,
  input  logic                    dec_rs_used,
  input  logic                    dec_rt_used,
  input  logic                    dec_src_fp,
  input  logic                    dec_wr,
  input  logic [$clog2(NREG)-1:0] dec_dst,
  input  logic                    dec_dst_fp,
  input  logic [LATW-1:0]         dec_lat,
  output logic                    stall,
  output logic                    issue,
  output logic [NREG-1:0]         busy_gpr,
  output logic [NREG-1:0]         busy_fpr,
  output logic                    wb_gpr_due,
  output logic                    wb_fpr_due
);

  localparam int unsigned IDXW = $clog2(NREG);
  localparam int unsigned NRES = 1 << LATW;

  logic [LATW-1:0] gpr_tmr [NREG];
  logic [LATW-1:0] fpr_tmr [NREG];
  // res[k] set: a writeback to that file lands k cycles from now (k = 0 is this cycle)
  logic [NRES-1:0] gpr_res;
  logic [NRES-1:0] fpr_res;

  logic [LATW-1:0] lat_eff;
  logic [NREG-1:0] src_busy;
  logic [NREG-1:0] dst_busy;
  logic [NRES-1:0] dst_res;
  logic            raw_hit;
  logic            waw_hit;
  logic            port_hit;
  logic            wr_issue;
  logic [NRES-1:0] res_set;

  assign lat_eff = (dec_lat == '0) ? LATW'(1) : dec_lat;

  // Busy bits straight from the timers; GPR 0 is hardwired idle.
  always_comb begin
    busy_gpr = '0;
    busy_fpr = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      busy_gpr[i] = (gpr_tmr[i] != '0);
      busy_fpr[i] = (fpr_tmr[i] != '0);
    end
    busy_gpr[0] = 1'b0;
  end

  // Hazard detection against existing state only (no look-ahead at retiring timers).
  always_comb begin
    src_busy = dec_src_fp ? busy_fpr : busy_gpr;
    dst_busy = dec_dst_fp ? busy_fpr : busy_gpr;
    dst_res  = dec_dst_fp ? fpr_res : gpr_res;
    raw_hit  = (dec_rs_used & src_busy[dec_rs]) | (dec_rt_used & src_busy[dec_rt]);
    waw_hit  = dec_wr & dst_busy[dec_dst];
    port_hit = dec_wr & dst_res[lat_eff];
    stall    = dec_valid & (raw_hit | waw_hit | port_hit);
    issue    = dec_valid & ~stall & ~flush;
    wr_issue = issue & dec_wr;
    res_set  = NRES'(1) << (lat_eff - LATW'(1));
  end

  assign wb_gpr_due = gpr_res[0];
  assign wb_fpr_due = fpr_res[0];

  // Timers count down to zero; an issuing write reloads its destination timer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(NREG); i++) begin
        gpr_tmr[i] <= '0;
        fpr_tmr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (wr_issue && !dec_dst_fp && (dec_dst == IDXW'(i)) && (i != 0)) begin
          gpr_tmr[i] <= lat_eff;
        end else if (gpr_tmr[i] != '0) begin
          gpr_tmr[i] <= gpr_tmr[i] - LATW'(1);
        end
        if (wr_issue && dec_dst_fp && (dec_dst == IDXW'(i))) begin
          fpr_tmr[i] <= lat_eff;
        end else if (fpr_tmr[i] != '0) begin
          fpr_tmr[i] <= fpr_tmr[i] - LATW'(1);
        end
      end
    end
  end

  // Reservation vectors shift toward slot 0; writes to GPR 0 still claim a slot.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      gpr_res <= '0;
      fpr_res <= '0;
    end else begin
      gpr_res <= (gpr_res >> 1) | ((wr_issue && !dec_dst_fp) ? res_set : '0);
      fpr_res <= (fpr_res >> 1) | ((wr_issue &&  dec_dst_fp) ? res_set : '0);
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: each step pushes its expected outputs to a queue,
// which is popped and compared once the outputs have settled for that cycle.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dec_valid;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        dec_rs_used;
  logic        dec_rt_used;
  logic        dec_src_fp;
  logic        dec_wr;
  logic [4:0]  dec_dst;
  logic        dec_dst_fp;
  logic [2:0]  dec_lat;
  logic        stall;
  logic        issue;
  logic [31:0] busy_gpr;
  logic [31:0] busy_fpr;
  logic        wb_gpr_due;
  logic        wb_fpr_due;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [31:0] bg;
    logic [31:0] bf;
    logic        wg;
    logic        wf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  id_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_src_fp(dec_src_fp), .dec_wr(dec_wr), .dec_dst(dec_dst), .dec_dst_fp(dec_dst_fp),
    .dec_lat(dec_lat), .stall(stall), .issue(issue), .busy_gpr(busy_gpr), .busy_fpr(busy_fpr),
    .wb_gpr_due(wb_gpr_due), .wb_fpr_due(wb_fpr_due)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int i);
    return 32'(1) << i;
  endfunction

  // One decode cycle: drive, queue expectation, settle, pop and compare, advance a clock.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu, input logic sfp, input logic wr,
                     input logic [4:0] dst, input logic dfp, input logic [2:0] lat, input logic fl,
                     input logic e_stall, input logic e_issue, input logic [31:0] e_bg,
                     input logic [31:0] e_bf, input logic e_wg, input logic e_wf);
    exp_t  e;
    string t;
    dec_valid = v; dec_rs = rs; dec_rs_used = rsu; dec_rt = rt; dec_rt_used = rtu;
    dec_src_fp = sfp; dec_wr = wr; dec_dst = dst; dec_dst_fp = dfp; dec_lat = lat; flush = fl;
    exp_q.push_back('{stall: e_stall, issue: e_issue, bg: e_bg, bf: e_bf, wg: e_wg, wf: e_wf});
    tag_q.push_back(tag);
    #3;
    if (exp_q.size() == 0) begin
      n_vec++; n_bad++;
      $error("FAIL %s queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec += 6;
      assert (stall === e.stall) else begin
        n_bad++; $error("FAIL %s stall: observed %0b expected %0b", t, stall, e.stall);
      end
      assert (issue === e.issue) else begin
        n_bad++; $error("FAIL %s issue: observed %0b expected %0b", t, issue, e.issue);
      end
      assert (busy_gpr === e.bg) else begin
        n_bad++; $error("FAIL %s busy_gpr: observed %h expected %h", t, busy_gpr, e.bg);
      end
      assert (busy_fpr === e.bf) else begin
        n_bad++; $error("FAIL %s busy_fpr: observed %h expected %h", t, busy_fpr, e.bf);
      end
      assert (wb_gpr_due === e.wg) else begin
        n_bad++; $error("FAIL %s wb_gpr_due: observed %0b expected %0b", t, wb_gpr_due, e.wg);
      end
      assert (wb_fpr_due === e.wf) else begin
        n_bad++; $error("FAIL %s wb_fpr_due: observed %0b expected %0b", t, wb_fpr_due, e.wf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthand for an idle decode cycle.
  task automatic idle(input string tag, input logic [31:0] e_bg, input logic [31:0] e_bf,
                      input logic e_wg, input logic e_wf);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_bg, e_bf, e_wg, e_wf);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_rs = '0; dec_rt = '0;
    dec_rs_used = 1'b0; dec_rt_used = 1'b0; dec_src_fp = 1'b0; dec_wr = 1'b0;
    dec_dst = '0; dec_dst_fp = 1'b0; dec_lat = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset then idle, and a non-writing instruction issuing freely
    idle("rst_idle", 0, 0, 0, 0);
    cyc("rst_nowr", 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // RAW on GPR r5 with latency 3
    cyc("raw_t0", 1, 0, 0, 0, 0, 0, 1, 5, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    cyc("raw_t1", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(5), 0, 0, 0);
    cyc("raw_t2", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(5), 0, 0, 0);
    cyc("raw_t3", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(5), 0, 1, 0);
    cyc("raw_t4", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Write-port collision: r1 lat 4, then r2 lat 2 stalls one cycle
    cyc("col_t0", 1, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0);
    idle("col_t1", b(1), 0, 0, 0);
    cyc("col_t2", 1, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 1, 0, b(1), 0, 0, 0);
    cyc("col_t3", 1, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0, 1, b(1), 0, 0, 0);
    idle("col_t4", b(1) | b(2), 0, 1, 0);
    idle("col_t5", b(2), 0, 1, 0);
    idle("col_t6", 0, 0, 0, 0);

    // File separation: f3 lat 6, then GPR reader of r3 writing r7 lat 5
    cyc("sep_t0", 1, 0, 0, 0, 0, 0, 1, 3, 1, 6, 0, 0, 1, 0, 0, 0, 0);
    cyc("sep_t1", 1, 3, 1, 0, 0, 0, 1, 7, 0, 5, 0, 0, 1, 0, b(3), 0, 0);
    cyc("sep_fraw", 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, b(7), b(3), 0, 0);
    for (int i = 3; i <= 5; i++) idle("sep_wait", b(7), b(3), 0, 0);
    idle("sep_t6", b(7), b(3), 1, 1);
    idle("sep_t7", 0, 0, 0, 0);

    // GPR 0 write with lat 0, then reading r0
    cyc("r0_t0", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("r0_t1", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle("r0_t2", 0, 0, 0, 0);

    // WAW on r4, including the stall while its timer is retiring
    cyc("waw_t0", 1, 0, 0, 0, 0, 0, 1, 4, 0, 2, 0, 0, 1, 0, 0, 0, 0);
    cyc("waw_t1", 1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 1, 0, b(4), 0, 0, 0);
    cyc("waw_t2", 1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 1, 0, b(4), 0, 1, 0);
    cyc("waw_t3", 1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    idle("waw_t4", b(4), 0, 1, 0);
    idle("waw_t5", 0, 0, 0, 0);

    // Flush coincident with a valid r10 write drops everything
    cyc("fl_t0", 1, 0, 0, 0, 0, 0, 1, 9, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    idle("fl_t1", b(9), 0, 0, 0);
    cyc("fl_t2", 1, 0, 0, 0, 0, 0, 1, 10, 0, 2, 1, 0, 0, b(9), 0, 0, 0);
    for (int i = 3; i <= 8; i++) idle("fl_after", 0, 0, 0, 0);

    // Reset asserted mid-operation
    cyc("mrst_t0", 1, 0, 0, 0, 0, 0, 1, 6, 1, 5, 0, 0, 1, 0, 0, 0, 0);
    reset = 1'b1;
    idle("mrst_t1", 0, b(6), 0, 0);
    reset = 1'b0;
    for (int i = 2; i <= 6; i++) idle("mrst_after", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
